// File: rtl/paralelo_serial_condl3.sv
// ---------------------------------------------------------------------------
// paralelo_serial_condl3
//   Byte-to-serial converter for the layer-3 PHY stage. It consumes the
//   valid/data byte stream from the layer-2 2:1 mux and shifts one word out
//   every WL clocks, MSB first, on the 8x bit clock. After every reset a
//   preamble of SYNC_WORDS idle symbols is sent before any data is accepted.
//   Whenever valid_in is low at a word boundary, the idle symbol is sent.
//
//   Optional feature: define SER_PARITY_EN to append an even-parity bit
//   after the LSB of every word (WL = DATA_W + 1). The port list is the
//   same in both builds.
//
// Ports
//   clk_32f      in   1       serial bit clock, rising edge
//   reset_L      in   1       asynchronous active-low reset
//   valid_in     in   1       data_in qualifier from the layer-2 mux
//   data_in      in   DATA_W  byte from the layer-2 mux
//   data_out     out  1       serial bit, MSB first (straight from a flop)
//   word_start   out  1       high while data_out carries the MSB of a word
//   data_active  out  1       high for every bit of a word taken from data_in
//   sync_done    out  1       high once the idle preamble has been loaded
//
// State table
//   state  | meaning
//   SYNC   | sending the idle preamble, inputs ignored
//   ACTIVE | preamble done, data/idle chosen by valid_in (left only by reset)
// ---------------------------------------------------------------------------
module paralelo_serial_condl3 #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC,
    parameter int                SYNC_WORDS = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              word_start,
    output logic              data_active,
    output logic              sync_done
);

`ifdef SER_PARITY_EN
    localparam int WL = DATA_W + 1;
`else
    localparam int WL = DATA_W;
`endif
    localparam int CNT_W = (WL > 1) ? $clog2(WL) : 1;
    localparam int WC_W  = $clog2(SYNC_WORDS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WL - 1);
    localparam logic [WC_W-1:0]  WC_FULL   = WC_W'(SYNC_WORDS);
    localparam logic [WC_W-1:0]  WC_PRELST = WC_W'(SYNC_WORDS - 1);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state,       state_nxt;
    logic [WL-1:0]     sr,          sr_nxt;
    logic [CNT_W-1:0]  bit_cnt,     bit_cnt_nxt;
    logic [WC_W-1:0]   word_cnt,    word_cnt_nxt;
    logic              word_start_nxt;
    logic              data_active_nxt;
    logic              sync_done_nxt;
    logic              load;

    // Build the on-line word: payload, plus the even-parity bit when enabled.
    function automatic logic [WL-1:0] frame(input logic [DATA_W-1:0] d);
`ifdef SER_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    // bit_cnt resets to its last value so the first edge after reset release
    // is already a word boundary and the preamble starts without a dead word.
    assign load = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state       <= SYNC;
            sr          <= '0;
            bit_cnt     <= BIT_LAST;
            word_cnt    <= '0;
            word_start  <= 1'b0;
            data_active <= 1'b0;
            sync_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            bit_cnt     <= bit_cnt_nxt;
            word_cnt    <= word_cnt_nxt;
            word_start  <= word_start_nxt;
            data_active <= data_active_nxt;
            sync_done   <= sync_done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sr_nxt          = {sr[WL-2:0], 1'b0};
        bit_cnt_nxt     = load ? '0 : bit_cnt + 1'b1;
        word_cnt_nxt    = word_cnt;
        word_start_nxt  = 1'b0;
        data_active_nxt = data_active;
        sync_done_nxt   = sync_done;

        if (load) begin
            word_start_nxt = 1'b1;
            unique case (state)
                SYNC: begin
                    sr_nxt          = frame(IDLE_SYM);
                    data_active_nxt = 1'b0;
                    if (word_cnt != WC_FULL)
                        word_cnt_nxt = word_cnt + 1'b1;
                    // Loading the last preamble word arms ACTIVE, so the very
                    // next boundary already samples data_in.
                    if (word_cnt == WC_PRELST)
                        state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    sync_done_nxt = 1'b1;
                    if (valid_in) begin
                        sr_nxt          = frame(data_in);
                        data_active_nxt = 1'b1;
                    end else begin
                        sr_nxt          = frame(IDLE_SYM);
                        data_active_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = sr[WL-1];

endmodule

// File: tb/tb_paralelo_serial_condl3.sv
module tb_paralelo_serial_condl3;

`ifdef SER_PARITY_EN
    localparam int WL = 9;
    localparam logic [WL-1:0] IDLE_W = 9'b101111001;
    localparam logic [WL-1:0] W07    = 9'b000001111;
`else
    localparam int WL = 8;
    localparam logic [WL-1:0] IDLE_W = 8'b10111100;
    localparam logic [WL-1:0] W07    = 8'b00000111;
`endif
    localparam logic [WL-1:0] WS_EXP = {1'b1, {(WL-1){1'b0}}};
    localparam logic [WL-1:0] DA_ON  = '1;
    localparam logic [WL-1:0] DA_OFF = '0;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_out, word_start, data_active, sync_done;

    int n_cmp = 0;
    int n_bad = 0;

    paralelo_serial_condl3 dut (
        .clk_32f     (clk_32f),
        .reset_L     (reset_L),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .word_start  (word_start),
        .data_active (data_active),
        .sync_done   (sync_done)
    );

    always #5 clk_32f = ~clk_32f;

    function automatic logic [WL-1:0] enc(input logic [7:0] d);
`ifdef SER_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_32f);
        #1;
    endtask

    // Captures one word starting at the next (load) edge and checks the
    // serial bits, the word_start pattern, data_active and sync_done.
    // chg_at >= 0 changes data_in to chg_val after that bit, mid-word.
    task automatic word_chk(input string tag, input logic [WL-1:0] exp_w,
                            input logic [WL-1:0] exp_da, input logic exp_sd,
                            input int chg_at, input logic [7:0] chg_val);
        logic [WL-1:0] w, ws, da;
        logic sd;
        w = '0; ws = '0; da = '0; sd = 1'b0;
        for (int i = 0; i < WL; i++) begin
            tick();
            w  = {w[WL-2:0],  data_out};
            ws = {ws[WL-2:0], word_start};
            da = {da[WL-2:0], data_active};
            if (i == 0) sd = sync_done;
            if (i == chg_at) data_in = chg_val;
        end
        check({tag, ".bits"}, 16'(w), 16'(exp_w));
        check({tag, ".ws"},   16'(ws), 16'(WS_EXP));
        check({tag, ".da"},   16'(da), 16'(exp_da));
        check({tag, ".sd"},   16'(sd), 16'(exp_sd));
    endtask

    task automatic do_reset;
        reset_L = 1'b0;
        repeat (3) tick();
        check("rst.data_out",    16'(data_out),    16'h0);
        check("rst.word_start",  16'(word_start),  16'h0);
        check("rst.data_active", 16'(data_active), 16'h0);
        check("rst.sync_done",   16'(sync_done),   16'h0);
        reset_L = 1'b1;
    endtask

    initial begin
        // 1: reset then idle preamble, sync_done at the 5th load edge
        valid_in = 1'b0;
        do_reset();
        for (int k = 1; k <= 4; k++)
            word_chk($sformatf("idle_w%0d", k), IDLE_W, DA_OFF, 1'b0, -1, 8'h00);
        word_chk("idle_w5", IDLE_W, DA_OFF, 1'b1, -1, 8'h00);

        // 3: back-to-back data words
        valid_in = 1'b1;
        data_in = 8'h00; word_chk("b2b_00", enc(8'h00), DA_ON, 1'b1, -1, 8'h00);
        data_in = 8'hFF; word_chk("b2b_FF", enc(8'hFF), DA_ON, 1'b1, -1, 8'h00);
        data_in = 8'h3C; word_chk("b2b_3C", enc(8'h3C), DA_ON, 1'b1, -1, 8'h00);

        // 4: mid-word input change has no effect until the next load edge
        data_in = 8'h55; word_chk("mid_55", enc(8'h55), DA_ON, 1'b1, 2, 8'hAA);
        word_chk("mid_AA", enc(8'hAA), DA_ON, 1'b1, -1, 8'h00);

        // idle insertion in ACTIVE
        valid_in = 1'b0;
        word_chk("gap_idle", IDLE_W, DA_OFF, 1'b1, -1, 8'h00);

        // 6: 8'h07 (parity bit 1 when enabled)
        valid_in = 1'b1; data_in = 8'h07;
        word_chk("w07", W07, DA_ON, 1'b1, -1, 8'h00);

        // 5: reset in the middle of a data word
        data_in = 8'hFF;
        repeat (4) tick();
        check("pre_rst.data_out", 16'(data_out), 16'h1);
        reset_L = 1'b0;
        #1;
        check("mid_rst.data_out",    16'(data_out),    16'h0);
        check("mid_rst.sync_done",   16'(sync_done),   16'h0);
        check("mid_rst.data_active", 16'(data_active), 16'h0);
        repeat (2) tick();
        reset_L = 1'b1;
        for (int k = 1; k <= 4; k++)
            word_chk($sformatf("rst_pre_w%0d", k), IDLE_W, DA_OFF, 1'b0, -1, 8'h00);
        word_chk("rst_data_FF", enc(8'hFF), DA_ON, 1'b1, -1, 8'h00);

        // 2: preamble masks valid data presented during sync
        data_in = 8'hA5;
        do_reset();
        for (int k = 1; k <= 4; k++)
            word_chk($sformatf("mask_w%0d", k), IDLE_W, DA_OFF, 1'b0, -1, 8'h00);
        word_chk("mask_A5", enc(8'hA5), DA_ON, 1'b1, -1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
